// File: rtl/step_stats.sv
// rtl/step_stats.sv - step counter with over-rate and high-activity statistics (optional distance via STEP_STATS_DIST_EN)
module step_stats #(
  parameter logic [15:0] SAT_MAX      = 16'd9999,
  parameter logic [8:0]  OVER_RATE    = 9'd32,
  parameter logic [3:0]  OVER_WINDOWS = 4'd9,
  parameter logic [8:0]  HI_RATE      = 9'd64,
  parameter logic [6:0]  HI_RUN       = 7'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        pulse,
  input  logic        sec_tick,
  output logic [15:0] step_count,
  output logic [7:0]  distance_hm,
  output logic [3:0]  over_secs,
  output logic [15:0] high_secs,
  output logic        high_act
);

  typedef enum logic [1:0] {IDLE, RUN, ACTIVE} state_t;

  state_t      state_q, state_d;
  logic        pulse_prev_q, tick_prev_q;
  logic [15:0] step_q, step_d;
  logic [7:0]  win_cnt_q, win_cnt_d;
  logic [3:0]  win_idx_q, win_idx_d;
  logic [3:0]  over_q, over_d;
  logic [15:0] high_q, high_d;
  logic [6:0]  run_len_q, run_len_d;
  logic        high_act_q, high_act_d;

  logic        pulse_edge, tick_edge, qual;
  logic [8:0]  win_val;
  logic [15:0] high_add;
  logic [16:0] high_sum;

  // Previous-sample registers start high so a level already present at reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_prev_q <= 1'b1;
      tick_prev_q  <= 1'b1;
    end else begin
      pulse_prev_q <= pulse;
      tick_prev_q  <= sec_tick;
    end
  end

  assign pulse_edge = pulse & ~pulse_prev_q;
  assign tick_edge  = sec_tick & ~tick_prev_q;

  // Counters, window bookkeeping and high-activity FSM next-state; clr overrides everything
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    win_cnt_d  = win_cnt_q;
    win_idx_d  = win_idx_q;
    over_d     = over_q;
    run_len_d  = run_len_q;
    high_add   = 16'd0;
    win_val    = {1'b0, win_cnt_q} + {8'd0, pulse_edge};
    qual       = (win_val >= HI_RATE);

    if (pulse_edge) begin
      if (step_q < SAT_MAX) step_d = step_q + 16'd1;
      if (win_cnt_q != 8'hFF) win_cnt_d = win_cnt_q + 8'd1;
    end

    if (tick_edge) begin
      win_cnt_d = 8'd0;
      if (win_idx_q < OVER_WINDOWS) begin
        win_idx_d = win_idx_q + 4'd1;
        if (win_val > OVER_RATE) over_d = over_q + 4'd1;
      end
      case (state_q)
        IDLE: begin
          if (qual) begin
            state_d   = RUN;
            run_len_d = 7'd1;
          end
        end
        RUN: begin
          if (qual) begin
            run_len_d = run_len_q + 7'd1;
            if (run_len_q + 7'd1 == HI_RUN) begin
              state_d  = ACTIVE;
              high_add = {9'd0, HI_RUN};
            end
          end else begin
            state_d   = IDLE;
            run_len_d = 7'd0;
          end
        end
        ACTIVE: begin
          if (qual) begin
            high_add = 16'd1;
          end else begin
            state_d   = IDLE;
            run_len_d = 7'd0;
          end
        end
        default: begin
          state_d   = IDLE;
          run_len_d = 7'd0;
        end
      endcase
    end

    high_sum = {1'b0, high_q} + {1'b0, high_add};
    high_d   = high_sum[16] ? 16'hFFFF : high_sum[15:0];

    if (clr) begin
      state_d   = IDLE;
      step_d    = 16'd0;
      win_cnt_d = 8'd0;
      win_idx_d = 4'd0;
      over_d    = 4'd0;
      run_len_d = 7'd0;
      high_d    = 16'd0;
    end

    high_act_d = (state_d == ACTIVE);
  end

  // Statistics and FSM state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      step_q     <= 16'd0;
      win_cnt_q  <= 8'd0;
      win_idx_q  <= 4'd0;
      over_q     <= 4'd0;
      run_len_q  <= 7'd0;
      high_q     <= 16'd0;
      high_act_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      win_cnt_q  <= win_cnt_d;
      win_idx_q  <= win_idx_d;
      over_q     <= over_d;
      run_len_q  <= run_len_d;
      high_q     <= high_d;
      high_act_q <= high_act_d;
    end
  end

  assign step_count = step_q;
  assign over_secs  = over_q;
  assign high_secs  = high_q;
  assign high_act   = high_act_q;

`ifdef STEP_STATS_DIST_EN
  logic [7:0] dist_q, dist_d;

  // Distance follows step_count one cycle later in 1024-step units
  always_comb begin
    dist_d = clr ? 8'd0 : {2'b00, step_q[15:10]};
  end

  // Distance register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dist_q <= 8'd0;
    else     dist_q <= dist_d;
  end

  assign distance_hm = dist_q;
`else
  assign distance_hm = 8'd0;
`endif

endmodule

// File: tb/tb_step_stats.sv
// tb/tb_step_stats.sv - self-checking bench for step_stats against a behavioural model
module tb_step_stats;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        pulse = 1'b0;
  logic        sec_tick = 1'b0;
  logic [15:0] step_count;
  logic [7:0]  distance_hm;
  logic [3:0]  over_secs;
  logic [15:0] high_secs;
  logic        high_act;

  int checks = 0;
  int errors = 0;

  step_stats dut (
    .clk(clk), .rst(rst), .clr(clr), .pulse(pulse), .sec_tick(sec_tick),
    .step_count(step_count), .distance_hm(distance_hm), .over_secs(over_secs),
    .high_secs(high_secs), .high_act(high_act)
  );

  always #5 clk = ~clk;

  // Behavioural model: totals, list-free window accounting, streak length of qualifying windows
  int m_step, m_dist, m_win, m_nwin, m_over, m_streak, m_high, m_val;
  bit m_pp, m_tp, m_pe, m_te;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_step = 0; m_dist = 0; m_win = 0; m_nwin = 0; m_over = 0;
      m_streak = 0; m_high = 0; m_pp = 1; m_tp = 1;
    end else begin
      m_pe = pulse && !m_pp;
      m_te = sec_tick && !m_tp;
      m_pp = pulse;
      m_tp = sec_tick;
      if (clr) begin
        m_step = 0; m_dist = 0; m_win = 0; m_nwin = 0; m_over = 0;
        m_streak = 0; m_high = 0;
      end else begin
        m_dist = m_step / 1024;
        if (m_te) begin
          m_val = (m_win > 255 ? 255 : m_win) + (m_pe ? 1 : 0);
          m_win = 0;
          if (m_nwin < 9 && m_val > 32) m_over++;
          m_nwin++;
          if (m_val >= 64) begin
            m_streak++;
            if (m_streak == 60) m_high += 60;
            else if (m_streak > 60) m_high += 1;
            if (m_high > 65535) m_high = 65535;
          end else begin
            m_streak = 0;
          end
        end else if (m_pe) begin
          m_win++;
        end
        if (m_pe && m_step < 9999) m_step++;
      end
    end
  end

  function automatic int exp_dist();
`ifdef STEP_STATS_DIST_EN
    return m_dist;
`else
    return 0;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      chk("step_count", int'(step_count), m_step);
      chk("distance_hm", int'(distance_hm), exp_dist());
      chk("over_secs", int'(over_secs), m_over);
      chk("high_secs", int'(high_secs), m_high);
      chk("high_act", int'(high_act), (m_streak >= 60) ? 1 : 0);
    end
  end

  task automatic cyc(bit p, bit t);
    pulse = p;
    sec_tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0);
      cyc(0, 0);
    end
  endtask

  // n steps then a tick; coin puts the last step on the tick cycle
  task automatic window(int n, bit coin);
    if (coin && n > 0) begin
      steps(n - 1);
      cyc(1, 1);
    end else begin
      steps(n);
      cyc(0, 1);
    end
    cyc(0, 0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc(0, 0);
    clr = 1'b0;
  endtask

  initial begin
    // Inputs high through reset release must not count as edges
    pulse = 1'b1;
    sec_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 1);
    cyc(0, 0);
    chk("lit_reset_step", int'(step_count), 0);
    chk("lit_reset_high_act", int'(high_act), 0);

    steps(10);
    chk("lit_10_steps", int'(step_count), 10);
    chk("lit_10_over", int'(over_secs), 0);
    chk("lit_10_idle", int'(high_act), 0);

    do_clr();
    for (int w = 0; w < 10; w++) window(40, 0);
    chk("lit_over9", int'(over_secs), 9);

    do_clr();
    for (int w = 0; w < 61; w++) window(64, 0);
    chk("lit_active_high", int'(high_secs), 61);
    chk("lit_active_flag", int'(high_act), 1);
    window(10, 0);
    chk("lit_drop_flag", int'(high_act), 0);
    chk("lit_drop_high", int'(high_secs), 61);

    do_clr();
    for (int w = 0; w < 59; w++) window(70, 0);
    window(63, 0);
    for (int w = 0; w < 60; w++) window(70, 0);
    chk("lit_rerun_high", int'(high_secs), 60);

    do_clr();
    window(33, 1);
    chk("lit_coincident_over", int'(over_secs), 1);
    chk("lit_coincident_step", int'(step_count), 33);
    window(0, 0);
    chk("lit_win_cleared", int'(over_secs), 1);

    do_clr();
    steps(10000);
    cyc(0, 0);
    chk("lit_sat_step", int'(step_count), 9999);
`ifdef STEP_STATS_DIST_EN
    chk("lit_sat_dist", int'(distance_hm), 9);
`else
    chk("lit_sat_dist", int'(distance_hm), 0);
`endif
    do_clr();
    chk("lit_clr_step", int'(step_count), 0);
    chk("lit_clr_dist", int'(distance_hm), 0);
    chk("lit_clr_over", int'(over_secs), 0);
    chk("lit_clr_high", int'(high_secs), 0);
    chk("lit_clr_act", int'(high_act), 0);

    // Randomized windows with occasional coincident edges, clears and a mid-window reset
    for (int w = 0; w < 40; w++) begin
      window($urandom_range(80, 0), 1'($urandom_range(1, 0)));
      if ($urandom_range(15, 0) == 0) do_clr();
      if (w == 20) begin
        steps(17);
        pulse = 1'b1;
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 0);
        chk("lit_midreset_step", int'(step_count), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
